fetch_unit: RTL and testbench

//  Instruction-fetch stage; sits directly upstream of the decode stage. Owns the PC.

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle instruction BRAM and
// presents {pc, inst, valid} to decode, holding them in a skid register under stall.
module fetch_unit #(
  parameter int          INST_SIZE = 10,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 halt,
  output logic [INST_SIZE-1:0] imem_addr,
  output logic                 imem_en,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          pc,
  output logic [31:0]          inst,
  output logic                 valid
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] req_pc, req_pc_nx;
  logic        req_valid, req_valid_nx;
  logic [31:0] hold_pc, hold_pc_nx;
  logic [31:0] hold_inst, hold_inst_nx;
  logic        hold_valid, hold_valid_nx;

  logic        issue;
  logic [31:0] issue_pc;
  logic [31:0] target_pc;
  logic        pres_valid;
  logic [31:0] pres_pc;
  logic [31:0] pres_inst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      req_valid  <= 1'b0;
      hold_pc    <= 32'h0;
      hold_inst  <= 32'h0;
      hold_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      fetch_pc   <= fetch_pc_nx;
      req_pc     <= req_pc_nx;
      req_valid  <= req_valid_nx;
      hold_pc    <= hold_pc_nx;
      hold_inst  <= hold_inst_nx;
      hold_valid <= hold_valid_nx;
    end
  end

  always_comb begin
    target_pc     = redirect_pc & 32'hFFFF_FFFC;
    state_nx      = state;
    fetch_pc_nx   = fetch_pc;
    req_pc_nx     = req_pc;
    req_valid_nx  = req_valid;
    hold_pc_nx    = hold_pc;
    hold_inst_nx  = hold_inst;
    hold_valid_nx = hold_valid;
    issue         = 1'b0;
    issue_pc      = fetch_pc;
    pres_valid    = 1'b0;
    pres_pc       = req_pc;
    pres_inst     = imem_rdata;

    case (state)
      BOOT: begin
        issue    = 1'b1;
        state_nx = RUN;
        if (redirect) issue_pc = target_pc;
      end

      RUN: begin
        pres_valid = req_valid;
        if (redirect) begin
          pres_valid = 1'b0;
          issue      = 1'b1;
          issue_pc   = target_pc;
        end else if (stall) begin
          hold_pc_nx    = req_pc;
          hold_inst_nx  = req_valid ? imem_rdata : 32'h0;
          hold_valid_nx = req_valid;
          state_nx      = STALL;
        end else if (halt && req_valid) begin
          state_nx = HALT;
        end else begin
          issue = 1'b1;
        end
      end

      STALL: begin
        pres_valid = hold_valid;
        pres_pc    = hold_pc;
        pres_inst  = hold_inst;
        if (redirect) begin
          // The held instruction is squashed and the skid register emptied.
          pres_valid    = 1'b0;
          hold_valid_nx = 1'b0;
          issue         = 1'b1;
          issue_pc      = target_pc;
          state_nx      = RUN;
        end else if (!stall) begin
          // Held instruction is consumed this cycle while the next fetch goes out.
          if (halt && hold_valid) begin
            state_nx = HALT;
          end else begin
            issue    = 1'b1;
            state_nx = RUN;
          end
          hold_valid_nx = 1'b0;
        end
      end

      HALT: begin
        pres_valid = 1'b0;
      end

      default: begin
        state_nx = BOOT;
      end
    endcase

    if (issue) begin
      fetch_pc_nx  = issue_pc + 32'd4;
      req_pc_nx    = issue_pc;
      req_valid_nx = 1'b1;
      state_nx     = RUN;
    end
  end

  // Reset must silence the BRAM immediately even though BOOT would otherwise issue.
  assign imem_en   = issue & rstn;
  assign imem_addr = issue_pc[INST_SIZE+1:2];
  assign valid     = pres_valid;
  assign inst      = pres_valid ? pres_inst : 32'h0;
  assign pc        = pres_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit (INST_SIZE=4 so address wrap is reachable).
module tb_fetch_unit;

  localparam int INST_SIZE = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 stall = 1'b0;
  logic                 redirect = 1'b0;
  logic [31:0]          redirect_pc = 32'h0;
  logic                 halt = 1'b0;
  logic [INST_SIZE-1:0] imem_addr;
  logic                 imem_en;
  logic [31:0]          imem_rdata = 32'h0;
  logic [31:0]          pc;
  logic [31:0]          inst;
  logic                 valid;

  logic [31:0] mem [16];
  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;

  fetch_unit #(.INST_SIZE(INST_SIZE), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .inst        (inst),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic hl);
    @(posedge clk);
    #1;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    #2;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #2;
  endtask

  // Valid outputs are compared against the scoreboard head; it is popped when decode consumes it.
  task automatic checkOutput(input string tag, input logic exp_valid);
    exp_t e;
    cmp({tag, "_valid"}, {31'h0, valid}, {31'h0, exp_valid});
    if (exp_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
        e = sb[0];
        cmp({tag, "_pc"}, pc, e.pc);
        cmp({tag, "_inst"}, inst, e.inst);
        if (!stall && !redirect) void'(sb.pop_front());
      end
    end else begin
      cmp({tag, "_inst0"}, inst, 32'h0);
      if (redirect && sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic checkIssue(input string tag, input logic [31:0] p);
    exp_t e;
    logic [3:0] w;
    w = p[5:2];
    cmp({tag, "_en"}, {31'h0, imem_en}, 32'h1);
    cmp({tag, "_addr"}, {28'h0, imem_addr}, {28'h0, w});
    e.pc   = p;
    e.inst = mem[w];
    sb.push_back(e);
  endtask

  task automatic checkIdle(input string tag);
    cmp({tag, "_en0"}, {31'h0, imem_en}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0001 + i * 32'h0101_0100;

    #3;
    cmp("rst_valid", {31'h0, valid}, 32'h0);
    cmp("rst_inst", inst, 32'h0);
    cmp("rst_pc", pc, 32'h0);
    cmp("rst_en", {31'h0, imem_en}, 32'h0);
    repeat (2) @(posedge clk);

    // Boot and straight-line fetch.
    releaseReset();
    checkOutput("boot", 1'b0);
    checkIssue("boot", 32'h0);
    for (int p = 0; p <= 'hC; p += 4) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("run_%0h", p), 1'b1);
      checkIssue($sformatf("run_%0h", p), p + 4);
    end

    // Three stall cycles at pc=0x10, then zero-bubble release.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("stall%0d", k), 1'b1);
      checkIdle($sformatf("stall%0d", k));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("release", 1'b1);
    checkIssue("release", 32'h14);
    for (int p = 'h14; p <= 'h1C; p += 4) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("run_%0h", p), 1'b1);
      checkIssue($sformatf("run_%0h", p), p + 4);
    end

    // Redirect to unaligned 0x103 while pc=0x20.
    applyStimulus(1'b0, 1'b1, 32'h103, 1'b0);
    checkOutput("redir", 1'b0);
    checkIssue("redir", 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("tgt100", 1'b1);
    checkIssue("tgt100", 32'h104);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("tgt104", 1'b1);
    checkIssue("tgt104", 32'h108);

    // Redirect while stalled in STALL wins and discards the held instruction.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("st108", 1'b1);
    checkIdle("st108");
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
    checkOutput("st_redir", 1'b0);
    checkIssue("st_redir", 32'h200);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("tgt200", 1'b1);
    checkIssue("tgt200", 32'h204);

    // Address wrap past 0x3C.
    applyStimulus(1'b0, 1'b1, 32'h38, 1'b0);
    checkOutput("redir38", 1'b0);
    checkIssue("redir38", 32'h38);
    for (int p = 'h38; p <= 'h40; p += 4) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("wrap_%0h", p), 1'b1);
      checkIssue($sformatf("wrap_%0h", p), p + 4);
    end

    // Halt at pc=0x30; later redirect ignored.
    applyStimulus(1'b0, 1'b1, 32'h30, 1'b0);
    checkOutput("redir30", 1'b0);
    checkIssue("redir30", 32'h30);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("halt30", 1'b1);
    checkIdle("halt30");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("halted", 1'b0);
    checkIdle("halted");
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    checkOutput("halt_redir", 1'b0);
    checkIdle("halt_redir");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("halt_stall", 1'b0);
    checkIdle("halt_stall");
    cmp("sb_empty", sb.size(), 32'h0);

    // Reset exits HALT; then reset asserted in the middle of a STALL cycle.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    rstn = 1'b0;
    #1;
    sb.delete();
    releaseReset();
    checkOutput("boot2", 1'b0);
    checkIssue("boot2", 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("st2a", 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("st2b", 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    cmp("midrst_valid", {31'h0, valid}, 32'h0);
    cmp("midrst_inst", inst, 32'h0);
    cmp("midrst_pc", pc, 32'h0);
    cmp("midrst_en", {31'h0, imem_en}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
